// File: rtl/field_cfg_loader_pkg.sv
// Shared types for the field configuration loader: load requests and loader FSM states.
package field_cfg_loader_pkg;

  typedef enum logic [1:0] {
    NO_REQ = 2'd0,
    CFG_1  = 2'd1,
    CFG_2  = 2'd2
  } load_cfg_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } fcl_state_t;

endpackage

// File: rtl/fcl_pattern_rom.sv
// Combinational pattern table: (configuration, row) -> row contents, bit c = column c alive.
// New start configurations are added here and in load_cfg_req_t only.
module fcl_pattern_rom
  import field_cfg_loader_pkg::*;
#(
  parameter int FIELD_W = 32,
  parameter int FIELD_H = 32,
  localparam int ROW_AW = $clog2(FIELD_H)
) (
  input  load_cfg_req_t       cfg_i,
  input  logic [ROW_AW-1:0]   row_i,
  output logic [FIELD_W-1:0]  data_o
);

  // Pattern lookup; any cell not named by a pattern stays dead
  always_comb begin
    data_o = {FIELD_W{1'b0}};
    case (cfg_i)
      CFG_1: begin
        if (row_i == ROW_AW'(0)) begin
          data_o = FIELD_W'(3'b010);
        end else if (row_i == ROW_AW'(1)) begin
          data_o = FIELD_W'(3'b100);
        end else if (row_i == ROW_AW'(2)) begin
          data_o = FIELD_W'(3'b111);
        end else begin
          data_o = {FIELD_W{1'b0}};
        end
      end
      CFG_2: begin
        // Horizontal blinker centred on the middle row and column
        if (row_i == ROW_AW'(FIELD_H / 2)) begin
          data_o = FIELD_W'(3'b111) << (FIELD_W / 2 - 1);
        end else begin
          data_o = {FIELD_W{1'b0}};
        end
      end
      default: data_o = {FIELD_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/field_cfg_loader.sv
// Responder side of the go/is_loading handshake: on go, writes the selected pattern into
// the field memory one row per accepted write, then pulses o_done.
module field_cfg_loader
  import field_cfg_loader_pkg::*;
#(
  parameter int FIELD_W = 32,
  parameter int FIELD_H = 32,
  localparam int ROW_AW = $clog2(FIELD_H)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_go,
  input  load_cfg_req_t       i_load_cfg_req,
  input  logic                i_wr_ready,
  output logic                o_is_loading,
  output logic                o_done,
  output logic                o_wr_en,
  output logic [ROW_AW-1:0]   o_wr_row,
  output logic [FIELD_W-1:0]  o_wr_data
);

  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(FIELD_H - 1);

  fcl_state_t          state_q, state_d;
  logic [ROW_AW-1:0]   row_q, row_d;
  load_cfg_req_t       cfg_q, cfg_d;
  logic [FIELD_W-1:0]  rom_data_s;

  logic                is_loading_q;
  logic                done_q;
  logic                wr_en_q;
  logic [ROW_AW-1:0]   wr_row_q;
  logic [FIELD_W-1:0]  wr_data_q;

  // Next-state logic; the cfg latch only moves when a load is accepted from IDLE
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cfg_d   = cfg_q;
    case (state_q)
      IDLE: begin
        if (i_go && (i_load_cfg_req != NO_REQ)) begin
          state_d = WRITE;
          row_d   = {ROW_AW{1'b0}};
          cfg_d   = i_load_cfg_req;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (i_wr_ready) begin
          if (row_q == LAST_ROW) begin
            state_d = DONE;
          end else begin
            row_d = row_q + ROW_AW'(1);
          end
        end else begin
          state_d = WRITE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pattern is looked up on the next row/cfg so the write data can be registered
  fcl_pattern_rom #(
    .FIELD_W (FIELD_W),
    .FIELD_H (FIELD_H)
  ) u_rom (
    .cfg_i  (cfg_d),
    .row_i  (row_d),
    .data_o (rom_data_s)
  );

  // State, counter, cfg latch and all outputs registered together
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= {ROW_AW{1'b0}};
      cfg_q        <= NO_REQ;
      is_loading_q <= 1'b0;
      done_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_row_q     <= {ROW_AW{1'b0}};
      wr_data_q    <= {FIELD_W{1'b0}};
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cfg_q        <= cfg_d;
      is_loading_q <= (state_d == WRITE);
      done_q       <= (state_d == DONE);
      wr_en_q      <= (state_d == WRITE);
      wr_row_q     <= (state_d == WRITE) ? row_d : {ROW_AW{1'b0}};
      wr_data_q    <= (state_d == WRITE) ? rom_data_s : {FIELD_W{1'b0}};
    end
  end

  assign o_is_loading = is_loading_q;
  assign o_done       = done_q;
  assign o_wr_en      = wr_en_q;
  assign o_wr_row     = wr_row_q;
  assign o_wr_data    = wr_data_q;

endmodule

// File: tb/tb_field_cfg_loader.sv
// Directed, table-driven bench for field_cfg_loader with an 8x8 field.
module tb_field_cfg_loader;
  import field_cfg_loader_pkg::*;

  logic          clk;
  logic          rst;
  logic          go;
  load_cfg_req_t cfg;
  logic          rdy;
  logic          is_loading;
  logic          done;
  logic          wr_en;
  logic [2:0]    wr_row;
  logic [7:0]    wr_data;

  int total;
  int bad;

  typedef struct {
    logic          rst;
    logic          go;
    load_cfg_req_t cfg;
    logic          rdy;
    logic [13:0]   exp;   // {is_loading, done, wr_en, row[2:0], data[7:0]}
    string         name;
  } vec_t;

  vec_t vecs[$];

  logic [7:0] glider[8];
  logic [7:0] blinker[8];

  field_cfg_loader #(
    .FIELD_W (8),
    .FIELD_H (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_go           (go),
    .i_load_cfg_req (cfg),
    .i_wr_ready     (rdy),
    .o_is_loading   (is_loading),
    .o_done         (done),
    .o_wr_en        (wr_en),
    .o_wr_row       (wr_row),
    .o_wr_data      (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic g, input load_cfg_req_t c, input logic rd,
                     input logic ld, input logic dn, input logic we,
                     input logic [2:0] row, input logic [7:0] d, input string nm);
    vec_t v;
    v.rst  = r;
    v.go   = g;
    v.cfg  = c;
    v.rdy  = rd;
    v.exp  = {ld, dn, we, row, d};
    v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [13:0] exp);
    logic [13:0] act;
    act = {is_loading, done, wr_en, wr_row, wr_data};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got ld=%0b dn=%0b we=%0b row=%0d data=%h, want ld=%0b dn=%0b we=%0b row=%0d data=%h",
               nm, act[13], act[12], act[11], act[10:8], act[7:0],
               exp[13], exp[12], exp[11], exp[10:8], exp[7:0]);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    glider  = '{8'h02, 8'h04, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    blinker = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h38, 8'h00, 8'h00, 8'h00};

    // 2: CFG_1 with ready always high
    add(1'b0, 1'b1, CFG_1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, glider[0], "c1_row0");
    for (int r = 1; r < 8; r++)
      add(1'b0, 1'b0, NO_REQ, 1'b1, 1'b1, 1'b0, 1'b1, 3'(r), glider[r], $sformatf("c1_row%0d", r));
    add(1'b0, 1'b0, NO_REQ, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, "c1_done");
    add(1'b0, 1'b0, NO_REQ, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, "c1_idle");

    // 3: CFG_2 with ready always high
    add(1'b0, 1'b1, CFG_2, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, blinker[0], "c2_row0");
    for (int r = 1; r < 8; r++)
      add(1'b0, 1'b0, NO_REQ, 1'b1, 1'b1, 1'b0, 1'b1, 3'(r), blinker[r], $sformatf("c2_row%0d", r));
    add(1'b0, 1'b0, NO_REQ, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, "c2_done");
    add(1'b0, 1'b0, NO_REQ, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, "c2_idle");

    // 4: CFG_1 with a 3-cycle stall while row 2 is presented
    add(1'b0, 1'b1, CFG_1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, glider[0], "st_row0");
    add(1'b0, 1'b0, NO_REQ, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, glider[1], "st_row1");
    add(1'b0, 1'b0, NO_REQ, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, glider[2], "st_row2");
    for (int k = 0; k < 3; k++)
      add(1'b0, 1'b0, NO_REQ, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, glider[2], $sformatf("st_hold%0d", k));
    for (int r = 3; r < 8; r++)
      add(1'b0, 1'b0, NO_REQ, 1'b1, 1'b1, 1'b0, 1'b1, 3'(r), glider[r], $sformatf("st_row%0d", r));
    add(1'b0, 1'b0, NO_REQ, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, "st_done");
    add(1'b0, 1'b0, NO_REQ, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, "st_idle");

    // 5: go with NO_REQ ignored; go pulses during WRITE and DONE ignored
    add(1'b0, 1'b1, NO_REQ, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, "noreq_a");
    add(1'b0, 1'b0, NO_REQ, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, "noreq_b");
    add(1'b0, 1'b1, CFG_1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, glider[0], "ig_row0");
    for (int r = 1; r < 8; r++)
      add(1'b0, (r == 2 || r == 5 || r == 7), CFG_2, 1'b1, 1'b1, 1'b0, 1'b1, 3'(r), glider[r],
          $sformatf("ig_row%0d", r));
    add(1'b0, 1'b1, CFG_2, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, "ig_done");
    add(1'b0, 1'b1, CFG_2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, "ig_idle");

    // 6: reset at row 3, then a fresh CFG_2 load restarts at row 0
    add(1'b0, 1'b1, CFG_2, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, blinker[0], "rs_row0");
    for (int r = 1; r < 4; r++)
      add(1'b0, 1'b0, NO_REQ, 1'b1, 1'b1, 1'b0, 1'b1, 3'(r), blinker[r], $sformatf("rs_row%0d", r));
    add(1'b1, 1'b0, NO_REQ, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, "rs_mid");
    add(1'b0, 1'b0, NO_REQ, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, "rs_idle");
    add(1'b0, 1'b1, CFG_2, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, blinker[0], "rr_row0");
    for (int r = 1; r < 8; r++)
      add(1'b0, 1'b0, NO_REQ, 1'b1, 1'b1, 1'b0, 1'b1, 3'(r), blinker[r], $sformatf("rr_row%0d", r));
    add(1'b0, 1'b0, NO_REQ, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, "rr_done");
    add(1'b0, 1'b0, NO_REQ, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, "rr_idle");

    // 1: reset held for 2 cycles with random inputs
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      go  = 1'($urandom_range(0, 1));
      cfg = load_cfg_req_t'($urandom_range(0, 2));
      rdy = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check($sformatf("reset%0d", k), 14'd0);
    end

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      go  = vecs[i].go;
      cfg = vecs[i].cfg;
      rdy = vecs[i].rdy;
      @(posedge clk);
      #1;
      check(vecs[i].name, vecs[i].exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
